// File: rtl/placement_pkg.sv
// Shared placement definitions: evaluator FSM encoding, unplaced-node marker and default sizes.
// Used by the placer and the read-side cost evaluator.
package placement_pkg;

  localparam int DEF_W      = 32;
  localparam int DEF_GRID_N = 12;
  localparam int DEF_N_EDGE = 142;

  localparam logic signed [DEF_W-1:0] NO_POS = -1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDGE,
    ST_POSA,
    ST_POSB,
    ST_CALC,
    ST_ACC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/placement_cost_evaluator_edge_cost.sv
// Combinational per-edge metrics: Manhattan deltas, full and 1-hop length, and on-grid validity.
// Arithmetic wraps modulo 2^W.
module edge_cost
  import placement_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int GRID_N = DEF_GRID_N
) (
  input  logic signed [W-1:0] ax,
  input  logic signed [W-1:0] ay,
  input  logic signed [W-1:0] bx,
  input  logic signed [W-1:0] by,
  output logic signed [W-1:0] dx,
  output logic signed [W-1:0] dy,
  output logic        [W-1:0] len,
  output logic signed [W-1:0] len_1hop,
  output logic                valid
);

  localparam logic signed [W-1:0] GRID_LIM = W'(GRID_N);
  localparam logic signed [W-1:0] UNPLACED = W'(NO_POS);
  localparam logic signed [W-1:0] ONE      = W'(1);

  function automatic logic signed [W-1:0] abs_w(input logic signed [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  function automatic logic on_grid(input logic signed [W-1:0] v);
    return (v != UNPLACED) && !v[W-1] && (v < GRID_LIM);
  endfunction

  assign dx  = abs_w(ax - bx);
  assign dy  = abs_w(ay - by);
  assign len = dx + dy;

  // ceil(d/2) for non-negative d is (d>>1) plus its low bit
  assign len_1hop = (dx >> 1) + W'(dx[0]) + (dy >> 1) + W'(dy[0]) - ONE;

  assign valid = on_grid(ax) && on_grid(ay) && on_grid(bx) && on_grid(by);

endmodule

// File: rtl/placement_cost_evaluator.sv
// Walks edge and position memories after placement, accumulating wirelength, 1-hop cost,
// longest edge and a count of edges touching unplaced/off-grid nodes. 5 cycles per edge.
module placement_cost_evaluator
  import placement_pkg::*;
#(
  parameter int N_EDGE = DEF_N_EDGE,
  parameter int GRID_N = DEF_GRID_N,
  parameter int W      = DEF_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                edge_re,
  output logic        [W-1:0] edge_addr,
  input  logic signed [W-1:0] edge_a,
  input  logic signed [W-1:0] edge_b,
  output logic                pos_re,
  output logic        [W-1:0] pos_addr,
  input  logic signed [W-1:0] pos_x,
  input  logic signed [W-1:0] pos_y,
  output logic signed [W-1:0] cost,
  output logic signed [W-1:0] cost_1hop,
  output logic        [W-1:0] max_len,
  output logic        [W-1:0] bad_cnt
);

  localparam logic [W-1:0]        LAST_IDX = W'(N_EDGE - 1);
  localparam logic signed [W-1:0] ONE      = W'(1);

  state_e state_q, state_d;

  logic        [W-1:0] i_q, i_d;
  logic signed [W-1:0] b_q, b_d;
  logic signed [W-1:0] ax_q, ax_d;
  logic signed [W-1:0] ay_q, ay_d;
  logic        [W-1:0] len_q, len_d;
  logic signed [W-1:0] len1_q, len1_d;
  logic                valid_q, valid_d;
  logic signed [W-1:0] cost_q, cost_d;
  logic signed [W-1:0] cost1_q, cost1_d;
  logic        [W-1:0] max_q, max_d;
  logic        [W-1:0] bad_q, bad_d;

  logic signed [W-1:0] ec_dx, ec_dy, ec_len1;
  logic        [W-1:0] ec_len;
  logic                ec_valid;

  // In CALC the B-node position is still held on pos_x/pos_y from the POSB read
  edge_cost #(
    .W      (W),
    .GRID_N (GRID_N)
  ) u_edge_cost (
    .ax       (ax_q),
    .ay       (ay_q),
    .bx       (pos_x),
    .by       (pos_y),
    .dx       (ec_dx),
    .dy       (ec_dy),
    .len      (ec_len),
    .len_1hop (ec_len1),
    .valid    (ec_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      b_q     <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      len_q   <= '0;
      len1_q  <= '0;
      valid_q <= 1'b0;
      cost_q  <= '0;
      cost1_q <= '0;
      max_q   <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      b_q     <= b_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      len_q   <= len_d;
      len1_q  <= len1_d;
      valid_q <= valid_d;
      cost_q  <= cost_d;
      cost1_q <= cost1_d;
      max_q   <= max_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    b_d       = b_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    len_d     = len_q;
    len1_d    = len1_q;
    valid_d   = valid_q;
    cost_d    = cost_q;
    cost1_d   = cost1_q;
    max_d     = max_q;
    bad_d     = bad_q;
    busy      = 1'b0;
    done      = 1'b0;
    edge_re   = 1'b0;
    edge_addr = '0;
    pos_re    = 1'b0;
    pos_addr  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cost_d  = '0;
          cost1_d = '0;
          max_d   = '0;
          bad_d   = '0;
          i_d     = '0;
          state_d = (N_EDGE == 0) ? ST_DONE : ST_EDGE;
        end
      end
      ST_EDGE: begin
        busy      = 1'b1;
        edge_re   = 1'b1;
        edge_addr = i_q;
        state_d   = ST_POSA;
      end
      ST_POSA: begin
        busy     = 1'b1;
        b_d      = edge_b;
        pos_re   = 1'b1;
        pos_addr = edge_a;
        state_d  = ST_POSB;
      end
      ST_POSB: begin
        busy     = 1'b1;
        ax_d     = pos_x;
        ay_d     = pos_y;
        pos_re   = 1'b1;
        pos_addr = b_q;
        state_d  = ST_CALC;
      end
      ST_CALC: begin
        busy    = 1'b1;
        len_d   = ec_len;
        len1_d  = ec_len1;
        valid_d = ec_valid;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        busy = 1'b1;
        if (valid_q) begin
          cost_d  = cost_q + $signed(len_q) - ONE;
          cost1_d = cost1_q + len1_q;
          if (len_q > max_q) max_d = len_q;
        end else begin
          bad_d = bad_q + W'(1);
        end
        i_d     = i_q + W'(1);
        state_d = (i_q == LAST_IDX) ? ST_DONE : ST_EDGE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cost      = cost_q;
  assign cost_1hop = cost1_q;
  assign max_len   = max_q;
  assign bad_cnt   = bad_q;

endmodule
